// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module : systolic_skew_feeder_if
// Brief  : Load-side and mesh-side signal bundle for the systolic skew feeder.
// Rev    : 1.0
// ============================================================================
interface systolic_skew_feeder_if #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                            load_valid_i;
    logic                            load_ready_o;
    logic [N-1:0][DATA_WIDTH-1:0]    load_west_i;
    logic [N-1:0][DATA_WIDTH-1:0]    load_north_i;
    logic                            start_i;
    logic [N-1:0][DATA_WIDTH-1:0]    west_o;
    logic [N-1:0][DATA_WIDTH-1:0]    north_o;
    logic                            inputs_valid_o;
    logic                            last_element_o;
    logic                            busy_o;
    logic [CNT_W-1:0]                count_o;
    logic                            done_o;

    modport master (
        output load_valid_i, load_west_i, load_north_i, start_i,
        input  load_ready_o, west_o, north_o, inputs_valid_o,
        input  last_element_o, busy_o, count_o, done_o
    );

    modport slave (
        input  load_valid_i, load_west_i, load_north_i, start_i,
        output load_ready_o, west_o, north_o, inputs_valid_o,
        output last_element_o, busy_o, count_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module : systolic_skew_feeder
// Brief  : Buffers K operand beats, then streams them diagonally skewed into
//          the systolic mesh boundary (lane i delayed by i cycles).
// Rev    : 1.0
// ============================================================================
module systolic_skew_feeder #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    systolic_skew_feeder_if.slave  bus
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int T_W    = $clog2(DEPTH + N);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    typedef logic [N-1:0][DATA_WIDTH-1:0] lanes_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [T_W-1:0]   t_q, t_d;
    lanes_t           west_q, west_d;
    lanes_t           north_q, north_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    lanes_t           west_mem  [0:(2**ADDR_W)-1];
    lanes_t           north_mem [0:(2**ADDR_W)-1];

    logic             w_load_ready;
    logic             w_accept;
    logic             w_launch;
    logic             w_finish;
    logic [CNT_W-1:0] w_k;
    int               w_kidx;

    always_comb begin
        w_load_ready = !rst_i && (state_q == IDLE) && (count_q < CNT_W'(DEPTH));
        w_accept     = bus.load_valid_i && w_load_ready;
        w_launch     = (state_q == IDLE) && bus.start_i && ((count_q != '0) || w_accept);
        w_finish     = (state_q == STREAM) && (int'(t_q) == int'(k_q) + N - 2);
        w_k          = w_launch ? (count_q + CNT_W'(w_accept)) : k_q;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        k_d     = k_q;
        t_d     = t_q;
        west_d  = '0;
        north_d = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        w_kidx  = 0;

        if (w_accept) begin
            count_d = count_q + CNT_W'(1);
        end

        if (w_launch) begin
            state_d = STREAM;
            k_d     = w_k;
            t_d     = '0;
        end else if (w_finish) begin
            state_d = IDLE;
            count_d = '0;
            t_d     = '0;
            done_d  = 1'b1;
        end else if (state_q == STREAM) begin
            t_d = t_q + T_W'(1);
        end

        // Precompute the lane values for the upcoming stream cycle t_d; a beat
        // accepted alongside start is bypassed since it is not yet in memory.
        if (w_launch || ((state_q == STREAM) && !w_finish)) begin
            for (int i = 0; i < N; i++) begin
                w_kidx = int'(t_d) - i;
                if ((w_kidx >= 0) && (w_kidx < int'(w_k))) begin
                    if (w_accept && (w_kidx == int'(count_q))) begin
                        west_d[i]  = bus.load_west_i[i];
                        north_d[i] = bus.load_north_i[i];
                    end else begin
                        west_d[i]  = west_mem[w_kidx[ADDR_W-1:0]][i];
                        north_d[i] = north_mem[w_kidx[ADDR_W-1:0]][i];
                    end
                end
            end
            valid_d = int'(t_d) < int'(w_k);
            last_d  = int'(t_d) == int'(w_k) + N - 2;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            k_q     <= '0;
            t_q     <= '0;
            west_q  <= '0;
            north_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            k_q     <= k_d;
            t_q     <= t_d;
            west_q  <= west_d;
            north_q <= north_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            west_mem[count_q[ADDR_W-1:0]]  <= bus.load_west_i;
            north_mem[count_q[ADDR_W-1:0]] <= bus.load_north_i;
        end
    end

    assign bus.load_ready_o   = w_load_ready;
    assign bus.west_o         = west_q;
    assign bus.north_o        = north_q;
    assign bus.inputs_valid_o = valid_q;
    assign bus.last_element_o = last_q;
    assign bus.busy_o         = (state_q == STREAM);
    assign bus.count_o        = count_q;
    assign bus.done_o         = done_q;
endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_systolic_skew_feeder
// Brief  : Directed self-checking bench for systolic_skew_feeder (N=2, DEPTH=8).
// Rev    : 1.0
// ============================================================================
module tb_systolic_skew_feeder;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int D  = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    systolic_skew_feeder_if #(.N(N), .DATA_WIDTH(DW), .DEPTH(D)) ifc ();

    systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifc.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {west1, west0, north1, north0, valid, last, busy, done}
    function automatic logic [131:0] pk(int w0, int w1, int n0, int n1,
                                        bit v, bit l, bit b, bit d);
        return {32'(w1), 32'(w0), 32'(n1), 32'(n0), v, l, b, d};
    endfunction

    function automatic logic [131:0] obs();
        return {ifc.west_o, ifc.north_o, ifc.inputs_valid_o,
                ifc.last_element_o, ifc.busy_o, ifc.done_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_beat(int w0, int w1, int n0, int n1);
        ifc.load_west_i  = {32'(w1), 32'(w0)};
        ifc.load_north_i = {32'(n1), 32'(n0)};
        ifc.load_valid_i = 1'b1;
        step();
        ifc.load_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        ifc.start_i = 1'b1;
        step();
        ifc.start_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (obs() !== 132'd0 || ifc.count_o !== 4'd0 || ifc.load_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got outs=%h count=%0d ready=%b expected all 0",
                     obs(), ifc.count_o, ifc.load_ready_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        vectors++;
        if (ifc.load_ready_o !== 1'b1 || ifc.count_o !== 4'd0 || obs() !== 132'd0) begin
            miscompares++;
            $display("FAIL reset_release: got ready=%b count=%0d outs=%h expected 1/0/0",
                     ifc.load_ready_o, ifc.count_o, obs());
        end
    endtask

    task automatic test_basic_skew();
        int w0[4] = '{1, 3, 5, 0};
        int w1[4] = '{0, 2, 4, 6};
        int n0[4] = '{10, 30, 50, 0};
        int n1[4] = '{0, 20, 40, 60};
        bit v[4]  = '{1, 1, 1, 0};
        bit l[4]  = '{0, 0, 0, 1};
        load_beat(1, 2, 10, 20);
        load_beat(3, 4, 30, 40);
        load_beat(5, 6, 50, 60);
        vectors++;
        if (ifc.count_o !== 4'd3) begin
            miscompares++;
            $display("FAIL basic_count: got %0d expected 3", ifc.count_o);
        end
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (obs() !== pk(w0[c], w1[c], n0[c], n1[c], v[c], l[c], 1'b1, 1'b0)) begin
                miscompares++;
                $display("FAIL basic_t%0d: got %h expected %h", c, obs(),
                         pk(w0[c], w1[c], n0[c], n1[c], v[c], l[c], 1'b1, 1'b0));
            end
            step();
        end
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0, 0, 0, 1) || ifc.count_o !== 4'd0 || ifc.load_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done: got outs=%h count=%0d ready=%b expected done only, count 0, ready 1",
                     obs(), ifc.count_o, ifc.load_ready_o);
        end
        step();
        vectors++;
        if (obs() !== 132'd0) begin
            miscompares++;
            $display("FAIL basic_after: got %h expected 0", obs());
        end
    endtask

    task automatic test_full_buffer();
        for (int i = 0; i < 8; i++) load_beat(i + 1, i + 101, i + 201, i + 301);
        vectors++;
        if (ifc.count_o !== 4'd8 || ifc.load_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_level: got count=%0d ready=%b expected 8/0",
                     ifc.count_o, ifc.load_ready_o);
        end
        load_beat(99, 99, 99, 99);
        vectors++;
        if (ifc.count_o !== 4'd8 || ifc.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ninth: got count=%0d busy=%b expected 8/0", ifc.count_o, ifc.busy_o);
        end
        pulse_start();
        for (int t = 0; t < 9; t++) begin
            vectors++;
            if (obs() !== pk((t < 8) ? t + 1 : 0, (t >= 1) ? t + 100 : 0,
                             (t < 8) ? t + 201 : 0, (t >= 1) ? t + 300 : 0,
                             t < 8, t == 8, 1'b1, 1'b0)) begin
                miscompares++;
                $display("FAIL full_t%0d: got %h expected %h", t, obs(),
                         pk((t < 8) ? t + 1 : 0, (t >= 1) ? t + 100 : 0,
                            (t < 8) ? t + 201 : 0, (t >= 1) ? t + 300 : 0,
                            t < 8, t == 8, 1'b1, 1'b0));
            end
            step();
        end
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0, 0, 0, 1) || ifc.count_o !== 4'd0) begin
            miscompares++;
            $display("FAIL full_done: got outs=%h count=%0d expected done only, count 0",
                     obs(), ifc.count_o);
        end
        step();
    endtask

    task automatic test_empty_start();
        pulse_start();
        vectors++;
        if (obs() !== 132'd0 || ifc.count_o !== 4'd0 || ifc.load_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_start: got outs=%h count=%0d ready=%b expected 0/0/1",
                     obs(), ifc.count_o, ifc.load_ready_o);
        end
        step();
        vectors++;
        if (obs() !== 132'd0) begin
            miscompares++;
            $display("FAIL empty_start_late: got %h expected 0", obs());
        end
    endtask

    task automatic test_back_to_back();
        int w0[4] = '{7, 9, 11, 0};
        int w1[4] = '{0, 8, 10, 12};
        int n0[4] = '{70, 90, 110, 0};
        int n1[4] = '{0, 80, 100, 120};
        bit v[4]  = '{1, 1, 1, 0};
        bit l[4]  = '{0, 0, 0, 1};
        load_beat(7, 8, 70, 80);
        load_beat(9, 10, 90, 100);
        ifc.load_west_i  = {32'd12, 32'd11};
        ifc.load_north_i = {32'd120, 32'd110};
        ifc.load_valid_i = 1'b1;
        ifc.start_i      = 1'b1;
        step();
        ifc.load_valid_i = 1'b0;
        ifc.start_i      = 1'b0;
        vectors++;
        if (ifc.count_o !== 4'd3) begin
            miscompares++;
            $display("FAIL simul_count: got %0d expected 3", ifc.count_o);
        end
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (obs() !== pk(w0[c], w1[c], n0[c], n1[c], v[c], l[c], 1'b1, 1'b0)) begin
                miscompares++;
                $display("FAIL simul_t%0d: got %h expected %h", c, obs(),
                         pk(w0[c], w1[c], n0[c], n1[c], v[c], l[c], 1'b1, 1'b0));
            end
            step();
        end
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0, 0, 0, 1) || ifc.count_o !== 4'd0) begin
            miscompares++;
            $display("FAIL simul_done: got outs=%h count=%0d expected done only, count 0",
                     obs(), ifc.count_o);
        end
        step();
    endtask

    task automatic test_interference();
        int w0[3] = '{1, 3, 0};
        int w1[3] = '{0, 2, 4};
        int n0[3] = '{5, 7, 0};
        int n1[3] = '{0, 6, 8};
        bit v[3]  = '{1, 1, 0};
        bit l[3]  = '{0, 0, 1};
        load_beat(1, 2, 5, 6);
        load_beat(3, 4, 7, 8);
        pulse_start();
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (obs() !== pk(w0[c], w1[c], n0[c], n1[c], v[c], l[c], 1'b1, 1'b0)
                || ifc.load_ready_o !== 1'b0 || ifc.count_o !== 4'd2) begin
                miscompares++;
                $display("FAIL interf_t%0d: got outs=%h ready=%b count=%0d expected %h ready 0 count 2",
                         c, obs(), ifc.load_ready_o, ifc.count_o,
                         pk(w0[c], w1[c], n0[c], n1[c], v[c], l[c], 1'b1, 1'b0));
            end
            ifc.load_valid_i = (c == 0);
            ifc.start_i      = (c == 0);
            ifc.load_west_i  = {32'hDEAD, 32'hBEEF};
            ifc.load_north_i = {32'hCAFE, 32'hF00D};
            step();
        end
        ifc.load_valid_i = 1'b0;
        ifc.start_i      = 1'b0;
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0, 0, 0, 1) || ifc.count_o !== 4'd0) begin
            miscompares++;
            $display("FAIL interf_done: got outs=%h count=%0d expected done only, count 0",
                     obs(), ifc.count_o);
        end
        step();
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 4; i++) load_beat(11 + i, 21 + i, 61 + i, 71 + i);
        pulse_start();
        step();
        vectors++;
        if (obs() !== pk(12, 21, 62, 71, 1, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL midrst_t1: got %h expected %h", obs(), pk(12, 21, 62, 71, 1, 0, 1, 0));
        end
        #2 rst_i = 1'b1;
        #1;
        vectors++;
        if (obs() !== 132'd0 || ifc.count_o !== 4'd0) begin
            miscompares++;
            $display("FAIL midrst_async: got outs=%h count=%0d expected 0/0", obs(), ifc.count_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        vectors++;
        if (ifc.load_ready_o !== 1'b1 || ifc.count_o !== 4'd0 || obs() !== 132'd0) begin
            miscompares++;
            $display("FAIL midrst_release: got ready=%b count=%0d outs=%h expected 1/0/0",
                     ifc.load_ready_o, ifc.count_o, obs());
        end
        load_beat(42, 43, 44, 45);
        pulse_start();
        vectors++;
        if (obs() !== pk(42, 0, 44, 0, 1, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL midrst_k1_t0: got %h expected %h", obs(), pk(42, 0, 44, 0, 1, 0, 1, 0));
        end
        step();
        vectors++;
        if (obs() !== pk(0, 43, 0, 45, 0, 1, 1, 0)) begin
            miscompares++;
            $display("FAIL midrst_k1_t1: got %h expected %h", obs(), pk(0, 43, 0, 45, 0, 1, 1, 0));
        end
        step();
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0, 0, 0, 1) || ifc.load_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_k1_done: got outs=%h ready=%b expected done only, ready 1",
                     obs(), ifc.load_ready_o);
        end
        step();
    endtask

    initial begin
        ifc.load_valid_i = 1'b0;
        ifc.start_i      = 1'b0;
        ifc.load_west_i  = '0;
        ifc.load_north_i = '0;
        test_reset();
        test_basic_skew();
        test_full_buffer();
        test_empty_start();
        test_back_to_back();
        test_interference();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
